// File: rtl/in_fifo_4x8_pkg.sv
// Package: in_fifo_pkg
// Purpose: constants and helper functions shared by the nibble-in / byte-out
//   receive FIFO (in_fifo_4x8), its bus interface and its packing sub-module.
// Contents:
//   DEFAULT_NUM_CH, DEFAULT_DEPTH  default channel count and word depth
//   ptr_width(depth)               read/write pointer width
//   cnt_width(depth)               occupancy counter width (holds 0..depth)
//   almost_value_ok(v)             legal ALMOSTEMPTY/ALMOSTFULL threshold
//   depth_ok(depth)                depth is a power of two and at least 4
package in_fifo_pkg;

  localparam int DEFAULT_NUM_CH = 10;
  localparam int DEFAULT_DEPTH  = 8;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // One extra value is needed so that a completely full FIFO is distinct from empty.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit almost_value_ok(input int v);
    return (v >= 1) && (v <= 2);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/in_fifo_4x8_if.sv
// Interface: in_fifo_4x8_if
// Purpose: groups the write, read and status signals of in_fifo_4x8.
// Signals:
//   WREN, D      nibble write strobe and per-channel nibbles (D[4c+3:4c])
//   RDEN         word pop strobe
//   Q            registered per-channel bytes (Q[8c+7:8c])
//   EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL  registered occupancy flags
//   WRERR, RDERR one-cycle overflow / underflow pulses
// Modports:
//   master  fabric / deserialiser side (drives WREN, D, RDEN)
//   slave   FIFO side
interface in_fifo_4x8_if
  import in_fifo_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH
) ();

  logic                  WREN;
  logic [4*NUM_CH-1:0]   D;
  logic                  RDEN;
  logic [8*NUM_CH-1:0]   Q;
  logic                  EMPTY;
  logic                  FULL;
  logic                  ALMOSTEMPTY;
  logic                  ALMOSTFULL;
  logic                  WRERR;
  logic                  RDERR;

  modport master (
    output WREN, D, RDEN,
    input  Q, EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL, WRERR, RDERR
  );

  modport slave (
    input  WREN, D, RDEN,
    output Q, EMPTY, FULL, ALMOSTEMPTY, ALMOSTFULL, WRERR, RDERR
  );

endinterface

// File: rtl/in_fifo_4x8_nibble_pack.sv
// Module: fifo_nibble_pack
// Purpose: pairs consecutive nibble writes into one byte per channel. The
//   first nibble of a pair is held in lo_q and becomes bits [3:0]; the second
//   nibble arrives on d and becomes bits [7:4] of the word presented together
//   with a push strobe. The parent decides whether the push is accepted; the
//   phase returns to "low nibble next" either way.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   wren        nibble write strobe
//   d           per-channel nibbles, channel c at d[4c+3:4c]
//   word        assembled word, channel c at word[8c+7:8c] (valid with push)
//   push        combinational: this write completes a word
module fifo_nibble_pack
  import in_fifo_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wren,
  input  logic [4*NUM_CH-1:0] d,
  output logic [8*NUM_CH-1:0] word,
  output logic                push
);

  logic                ph_q, ph_d;
  logic [4*NUM_CH-1:0] lo_q, lo_d;

  always_comb begin
    ph_d = ph_q;
    lo_d = lo_q;
    push = 1'b0;
    if (wren) begin
      if (!ph_q) begin
        lo_d = d;
        ph_d = 1'b1;
      end else begin
        push = 1'b1;
        ph_d = 1'b0;
      end
    end
  end

  always_comb begin
    word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      word[8*c +: 8] = {d[4*c +: 4], lo_q[4*c +: 4]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q <= 1'b0;
      lo_q <= '0;
    end else begin
      ph_q <= ph_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/in_fifo_4x8.sv
// Module: in_fifo_4x8
// Purpose: receive-direction FIFO. Nibbles written on NUM_CH channels are
//   packed in pairs into bytes, DEPTH words are buffered, and all channels are
//   popped together into a registered Q. Single clock domain.
// Ports:
//   CLK      clock, rising edge
//   RESET_N  asynchronous active-low reset
//   bus      in_fifo_4x8_if slave modport (WREN, D, RDEN in; Q and flags out)
module in_fifo_4x8
  import in_fifo_pkg::*;
#(
  parameter int NUM_CH             = DEFAULT_NUM_CH,
  parameter int DEPTH              = DEFAULT_DEPTH,
  parameter int ALMOST_EMPTY_VALUE = 1,
  parameter int ALMOST_FULL_VALUE  = 1
) (
  input  logic          CLK,
  input  logic          RESET_N,
  in_fifo_4x8_if.slave  bus
);

  localparam int PW = ptr_width(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam int WW = 8 * NUM_CH;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AEV_C   = CW'(ALMOST_EMPTY_VALUE);
  localparam logic [CW-1:0] AFV_C   = CW'(ALMOST_FULL_VALUE);

  if (!almost_value_ok(ALMOST_EMPTY_VALUE)) begin : g_bad_aev
    $error("in_fifo_4x8: ALMOST_EMPTY_VALUE must be 1 or 2");
  end
  if (!almost_value_ok(ALMOST_FULL_VALUE)) begin : g_bad_afv
    $error("in_fifo_4x8: ALMOST_FULL_VALUE must be 1 or 2");
  end
  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("in_fifo_4x8: DEPTH must be a power of two and at least 4");
  end

  logic [WW-1:0] pack_word;
  logic          pack_push;

  fifo_nibble_pack #(
    .NUM_CH (NUM_CH)
  ) u_pack (
    .clk   (CLK),
    .rst_n (RESET_N),
    .wren  (bus.WREN),
    .d     (bus.D),
    .word  (pack_word),
    .push  (pack_push)
  );

  logic [WW-1:0] mem [DEPTH];

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] q_q, q_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          aempty_q, aempty_d;
  logic          afull_q, afull_d;
  logic          wrerr_q, wrerr_d;
  logic          rderr_q, rderr_d;
  logic          push_ok;
  logic          pop;

  // A pop on the same edge frees a slot, so a completing write into a full
  // FIFO is still accepted when RDEN is high (FULL implies not EMPTY).
  // The memory write is non-blocking, so a read of the slot being written on
  // the same edge returns the old (oldest) word.
  always_comb begin
    push_ok  = pack_push && (!full_q || bus.RDEN);
    pop      = bus.RDEN && !empty_q;
    wrerr_d  = pack_push && !push_ok;
    rderr_d  = bus.RDEN && empty_q;

    wptr_d   = push_ok ? wptr_q + PW'(1) : wptr_q;
    rptr_d   = pop     ? rptr_q + PW'(1) : rptr_q;
    q_d      = pop     ? mem[rptr_q]     : q_q;

    count_d  = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CW'(1);
    end

    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_C);
    aempty_d = (count_d <= AEV_C);
    afull_d  = ((DEPTH_C - count_d) <= AFV_C);
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wptr_q] <= pack_word;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      q_q      <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      wrerr_q  <= 1'b0;
      rderr_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      q_q      <= q_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      wrerr_q  <= wrerr_d;
      rderr_q  <= rderr_d;
    end
  end

  assign bus.Q           = q_q;
  assign bus.EMPTY       = empty_q;
  assign bus.FULL        = full_q;
  assign bus.ALMOSTEMPTY = aempty_q;
  assign bus.ALMOSTFULL  = afull_q;
  assign bus.WRERR       = wrerr_q;
  assign bus.RDERR       = rderr_q;

endmodule

// File: tb/tb_in_fifo_4x8.sv
// Testbench: tb_in_fifo_4x8
// Purpose: directed test of in_fifo_4x8 (NUM_CH=10, DEPTH=8, both almost
//   thresholds 1). Words written as pattern k carry, per channel c, the byte
//   {k[3:0], c[3:0]}: the low nibble is the channel number, the high nibble k.
module tb_in_fifo_4x8;

  localparam int NUM_CH = 10;
  localparam int DEPTH  = 8;

  logic CLK;
  logic RESET_N;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  in_fifo_4x8_if #(.NUM_CH(NUM_CH)) bus ();

  in_fifo_4x8 #(
    .NUM_CH             (NUM_CH),
    .DEPTH              (DEPTH),
    .ALMOST_EMPTY_VALUE (1),
    .ALMOST_FULL_VALUE  (1)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Low-nibble write data: channel c carries c.
  function automatic logic [4*NUM_CH-1:0] lo_nib();
    logic [4*NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[4*c +: 4] = 4'(c);
    return v;
  endfunction

  // High-nibble write data: every channel carries k.
  function automatic logic [4*NUM_CH-1:0] hi_nib(input int k);
    logic [4*NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[4*c +: 4] = 4'(k);
    return v;
  endfunction

  function automatic logic [8*NUM_CH-1:0] word_val(input int k);
    logic [8*NUM_CH-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[8*c +: 8] = {4'(k), 4'(c)};
    return v;
  endfunction

  // Drive inputs just after an edge, then advance to 1 time unit past the next edge.
  task automatic apply_stimulus(input logic w, input logic [4*NUM_CH-1:0] dd, input logic r);
    bus.WREN = w;
    bus.D    = dd;
    bus.RDEN = r;
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input int k);
    apply_stimulus(1'b1, lo_nib(), 1'b0);
    apply_stimulus(1'b1, hi_nib(k), 1'b0);
  endtask

  task automatic check_output(input string tag, input logic [8*NUM_CH-1:0] obs,
                              input logic [8*NUM_CH-1:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic e, input logic f,
                             input logic ae, input logic af);
    check_output({tag, " EMPTY"},       80'(bus.EMPTY),       80'(e));
    check_output({tag, " FULL"},        80'(bus.FULL),        80'(f));
    check_output({tag, " ALMOSTEMPTY"}, 80'(bus.ALMOSTEMPTY), 80'(ae));
    check_output({tag, " ALMOSTFULL"},  80'(bus.ALMOSTFULL),  80'(af));
  endtask

  initial begin
    logic [4*NUM_CH-1:0]  d_first, d_second;
    logic [8*NUM_CH-1:0]  exp_q;
    int                   k;

    RESET_N  = 1'b0;
    bus.WREN = 1'b0;
    bus.D    = '0;
    bus.RDEN = 1'b0;

    // Test 1: reset values, then an underflow read.
    repeat (2) @(posedge CLK);
    #1;
    check_flags("reset", 1'b1, 1'b0, 1'b1, 1'b0);
    check_output("reset Q", bus.Q, '0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    check_flags("idle", 1'b1, 1'b0, 1'b1, 1'b0);
    check_output("idle WRERR", 80'(bus.WRERR), 80'(0));
    check_output("idle RDERR", 80'(bus.RDERR), 80'(0));
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("underflow RDERR", 80'(bus.RDERR), 80'(1));
    check_output("underflow Q", bus.Q, '0);
    apply_stimulus(1'b0, '0, 1'b0);
    check_output("underflow RDERR drop", 80'(bus.RDERR), 80'(0));

    // Test 2: pack order. ch0 gets A then 5, channel c gets c then c+1.
    for (int c = 0; c < NUM_CH; c++) begin
      d_first[4*c +: 4]  = (c == 0) ? 4'hA : 4'(c);
      d_second[4*c +: 4] = (c == 0) ? 4'h5 : 4'(c + 1);
      exp_q[8*c +: 8]    = (c == 0) ? 8'h5A : {4'(c + 1), 4'(c)};
    end
    apply_stimulus(1'b1, d_first, 1'b0);
    check_output("half word EMPTY", 80'(bus.EMPTY), 80'(1));
    apply_stimulus(1'b1, d_second, 1'b0);
    check_flags("one word", 1'b0, 1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("pack ch0", 80'(bus.Q[7:0]), 80'(8'h5A));
    check_output("pack ch1", 80'(bus.Q[15:8]), 80'(8'h21));
    check_output("pack all", bus.Q, exp_q);
    check_output("pack RDERR", 80'(bus.RDERR), 80'(0));
    check_flags("pack drained", 1'b1, 1'b0, 1'b1, 1'b0);

    // Test 3: fill to FULL, overflow, drain in order.
    for (int w = 1; w <= DEPTH; w++) begin
      write_word(w);
      if (w == 2) check_flags("fill 2", 1'b0, 1'b0, 1'b0, 1'b0);
      if (w == 6) check_flags("fill 6", 1'b0, 1'b0, 1'b0, 1'b0);
      if (w == 7) check_flags("fill 7", 1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_flags("fill 8", 1'b0, 1'b1, 1'b0, 1'b1);
    apply_stimulus(1'b1, lo_nib(), 1'b0);
    check_output("overflow first nibble WRERR", 80'(bus.WRERR), 80'(0));
    apply_stimulus(1'b1, hi_nib(9), 1'b0);
    check_output("overflow WRERR", 80'(bus.WRERR), 80'(1));
    check_output("overflow FULL", 80'(bus.FULL), 80'(1));
    apply_stimulus(1'b0, '0, 1'b0);
    check_output("overflow WRERR drop", 80'(bus.WRERR), 80'(0));
    for (int w = 1; w <= DEPTH; w++) begin
      apply_stimulus(1'b0, '0, 1'b1);
      check_output($sformatf("drain3 word %0d", w), bus.Q, word_val(w));
      if (w == 1) check_flags("drain3 1", 1'b0, 1'b0, 1'b0, 1'b1);
      if (w == 7) check_flags("drain3 7", 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check_flags("drain3 done", 1'b1, 1'b0, 1'b1, 1'b0);

    // Test 4: full plus simultaneous completing write and pop.
    for (int w = 1; w <= DEPTH; w++) write_word(w);
    apply_stimulus(1'b1, lo_nib(), 1'b0);
    apply_stimulus(1'b1, hi_nib(9), 1'b1);
    check_output("full rw Q", bus.Q, word_val(1));
    check_output("full rw WRERR", 80'(bus.WRERR), 80'(0));
    check_output("full rw FULL", 80'(bus.FULL), 80'(1));
    apply_stimulus(1'b0, '0, 1'b0);
    check_output("full rw FULL hold", 80'(bus.FULL), 80'(1));
    for (int w = 2; w <= DEPTH + 1; w++) begin
      apply_stimulus(1'b0, '0, 1'b1);
      check_output($sformatf("drain4 word %0d", w), bus.Q, word_val(w));
    end
    check_flags("drain4 done", 1'b1, 1'b0, 1'b1, 1'b0);

    // Test 5: three rounds of push 5 / pop 5 so both pointers wrap.
    k = 10;
    for (int round = 0; round < 3; round++) begin
      for (int w = 0; w < 5; w++) write_word(k + w);
      check_flags($sformatf("wrap%0d filled", round), 1'b0, 1'b0, 1'b0, 1'b0);
      for (int w = 0; w < 5; w++) begin
        apply_stimulus(1'b0, '0, 1'b1);
        check_output($sformatf("wrap%0d word %0d", round, w), bus.Q, word_val(k + w));
      end
      check_flags($sformatf("wrap%0d drained", round), 1'b1, 1'b0, 1'b1, 1'b0);
      k += 5;
    end

    // Test 6: asynchronous reset with 5 words stored and a pending half-word.
    for (int w = 0; w < 5; w++) write_word(3 + w);
    apply_stimulus(1'b1, lo_nib(), 1'b0);
    bus.WREN = 1'b0;
    bus.D    = '0;
    #2;
    RESET_N = 1'b0;
    #1;
    check_flags("async reset", 1'b1, 1'b0, 1'b1, 1'b0);
    check_output("async reset Q", bus.Q, '0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;
    apply_stimulus(1'b1, lo_nib(), 1'b0);
    check_output("post reset low nibble EMPTY", 80'(bus.EMPTY), 80'(1));
    apply_stimulus(1'b1, hi_nib(7), 1'b0);
    check_output("post reset word EMPTY", 80'(bus.EMPTY), 80'(0));
    apply_stimulus(1'b0, '0, 1'b1);
    check_output("post reset Q", bus.Q, word_val(7));
    check_flags("post reset drained", 1'b1, 1'b0, 1'b1, 1'b0);

    apply_stimulus(1'b0, '0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
